// File: rtl/count_run_controller_pkg.sv
// Shared definitions for the count run controller: FSM state encodings,
// the width helper used to size counters, and the wrap-request clamp rule.
package count_run_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } run_state_e;

    // Number of bits needed to hold `value` distinct codes (at least 1).
    function automatic int ceil_log2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Wrap requests above the supported maximum run the maximum instead.
    function automatic int clamp_wraps(input int req, input int max_wraps);
        return (req > max_wraps) ? max_wraps : req;
    endfunction

endpackage

// File: rtl/count_run_controller_prescale_tick.sv
// Modulo-PRESCALE tick counter. Advances only while `run` is high, can be
// cleared synchronously, and flags its terminal count combinationally.
module prescale_tick #(
    parameter int PRESCALE = 4,
    parameter int PBITS    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tc
);

    logic [PBITS-1:0] cnt_q;
    logic [PBITS-1:0] cnt_d;

    // Next count: clear wins, otherwise step and wrap only while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == PBITS'(PRESCALE - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PBITS'(1);
            end
        end
    end

    // Count register; reset is active low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count marks the last clock of each prescale period.
    always_comb begin
        tc = (cnt_q == PBITS'(PRESCALE - 1));
    end

endmodule

// File: rtl/count_run_controller.sv
// Run controller for a downstream wrap counter. Drives the counter's enable
// through a prescaler, counts wraps seen on its flag, and sequences one-shot
// or continuous runs with start/stop/pause control.
module count_run_controller
    import count_run_controller_pkg::*;
#(
    parameter int PRESCALE  = 4,
    parameter int MAX_WRAPS = 8,
    parameter int WBITS     = ceil_log2(MAX_WRAPS + 1),
    parameter int PBITS     = ceil_log2(PRESCALE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WBITS-1:0] wraps_req,
    input  logic             counter_flag,
    output logic             counter_enable,
    output logic             busy,
    output logic             done,
    output logic [WBITS-1:0] wrap_count
);

    run_state_e       state_q;
    run_state_e       state_d;
    logic [WBITS-1:0] target_q;
    logic [WBITS-1:0] target_d;
    logic [WBITS-1:0] wrap_count_q;
    logic [WBITS-1:0] wrap_count_d;
    logic             pre_tc;
    logic             pre_run;
    logic             pre_clear;
    logic             wrap_event;
    logic             final_wrap;
    logic             accept_start;

    // Prescaler runs in RUN regardless of pause/stop so a pause entered
    // mid-period resumes at the next phase; it restarts at 0 on every start.
    always_comb begin
        accept_start = (state_q == ST_IDLE) && start;
        pre_run      = (state_q == ST_RUN);
        pre_clear    = accept_start;
    end

    prescale_tick #(
        .PRESCALE (PRESCALE),
        .PBITS    (PBITS)
    ) u_prescale_tick (
        .clk   (clk),
        .reset (reset),
        .run   (pre_run),
        .clear (pre_clear),
        .tc    (pre_tc)
    );

    // Enable comes only from registered state and the prescaler, gated by
    // the control levels, so the counter's flag never feeds back into it.
    always_comb begin
        counter_enable = (state_q == ST_RUN) && pre_tc && !pause && !stop;
        wrap_event     = counter_enable && counter_flag;
        final_wrap     = wrap_event && (target_q != '0)
                         && (wrap_count_q == target_q - WBITS'(1));
    end

    // State register; reset is active low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stop beats pause, pause beats the completing wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (final_wrap) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Target is latched (clamped) and the wrap count cleared on an accepted
    // start; afterwards every wrap event bumps the count, modulo its width.
    always_comb begin
        target_d     = target_q;
        wrap_count_d = wrap_count_q;
        if (accept_start) begin
            target_d     = WBITS'(clamp_wraps(int'(wraps_req), MAX_WRAPS));
            wrap_count_d = '0;
        end else if (wrap_event) begin
            wrap_count_d = wrap_count_q + WBITS'(1);
        end
    end

    // Run bookkeeping registers; reset is active low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q     <= '0;
            wrap_count_q <= '0;
        end else begin
            target_q     <= target_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        done       = (state_q == ST_DONE);
        wrap_count = wrap_count_q;
    end

endmodule

// File: tb/tb_count_run_controller.sv
// Directed scoreboard bench for count_run_controller with a modulo-8
// downstream counter model providing counter_flag.
module tb_count_run_controller;

    localparam int PRESCALE  = 4;
    localparam int MAX_WRAPS = 8;
    localparam int WBITS     = 4;

    typedef struct {
        int due_cyc;
        int wc;
    } done_exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             pause = 1'b0;
    logic [WBITS-1:0] wraps_req = '0;
    logic             counter_flag;
    logic             counter_enable;
    logic             busy;
    logic             done;
    logic [WBITS-1:0] wrap_count;
    logic [2:0]       ds_count;

    int        cyc = 0;
    int        en_count = 0;
    int        first_en_cyc = -1;
    int        tests_run = 0;
    int        tests_failed = 0;
    done_exp_t exp_q[$];

    count_run_controller #(
        .PRESCALE  (PRESCALE),
        .MAX_WRAPS (MAX_WRAPS),
        .WBITS     (WBITS),
        .PBITS     (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .pause          (pause),
        .wraps_req      (wraps_req),
        .counter_flag   (counter_flag),
        .counter_enable (counter_enable),
        .busy           (busy),
        .done           (done),
        .wrap_count     (wrap_count)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Downstream counter 0..7: flag high at 7, wraps to 0 on the next enable.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ds_count <= 3'd0;
        end else if (counter_enable) begin
            ds_count <= ds_count + 3'd1;
        end
    end

    assign counter_flag = (ds_count == 3'd7);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitUntil(input int target_cyc);
        while (cyc < target_cyc) begin
            @(negedge clk);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Pulse (or hold) start with a wrap request; c is the cycle index at
    // which start was raised, so RUN is entered at the edge making cyc=c+1.
    task automatic applyStimulus(input int req, input bit hold_start, output int c);
        @(negedge clk);
        en_count     = 0;
        first_en_cyc = -1;
        wraps_req    = WBITS'(req);
        start        = 1'b1;
        c            = cyc;
        @(negedge clk);
        if (!hold_start) begin
            start = 1'b0;
        end
    endtask

    // Monitor: counts enable pulses and matches each done pulse against the
    // scoreboard, flagging unexpected or overdue completions.
    initial begin : monitor
        done_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (counter_enable) begin
                en_count++;
                if (first_en_cyc < 0) begin
                    first_en_cyc = cyc;
                end
                checkOutput("enable_only_when_busy", 32'(busy), 32'd1);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done_cycle", cyc, e.due_cyc);
                    checkOutput("done_wrap_count", 32'(wrap_count), e.wc);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due_cyc) begin
                e = exp_q.pop_front();
                checkOutput("done_missing", 32'(done), 32'd1);
            end
        end
    end

    initial begin : stimulus
        int c;

        // Reset values while reset is held low, then idle after release.
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_enable", 32'(counter_enable), 32'd0);
        checkOutput("reset_wrap_count", 32'(wrap_count), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_reset_busy", 32'(busy), 32'd0);

        // One-shot of 2 wraps: 16 enables, done 64 edges after RUN entry.
        applyStimulus(2, 1'b0, c);
        exp_q.push_back('{due_cyc: c + 65, wc: 2});
        checkOutput("t1_busy_after_start", 32'(busy), 32'd1);
        waitUntil(c + 70);
        #3;
        checkOutput("t1_enable_count", en_count, 32'd16);
        checkOutput("t1_first_enable_cycle", first_en_cyc, c + 4);
        checkOutput("t1_wrap_count", 32'(wrap_count), 32'd2);
        checkOutput("t1_busy_after", 32'(busy), 32'd0);

        // Continuous run stopped on an enable cycle after 3 wraps.
        resetDut();
        applyStimulus(0, 1'b0, c);
        waitUntil(c + 100);
        stop = 1'b1;
        #1;
        checkOutput("t2_enable_gated_by_stop", 32'(counter_enable), 32'd0);
        @(negedge clk);
        stop = 1'b0;
        #3;
        checkOutput("t2_busy_after_stop", 32'(busy), 32'd0);
        checkOutput("t2_wrap_count", 32'(wrap_count), 32'd3);
        checkOutput("t2_enable_count", en_count, 32'd24);
        waitUntil(c + 110);
        #3;
        checkOutput("t2_no_enable_after_stop", en_count, 32'd24);
        checkOutput("t2_wrap_count_held", 32'(wrap_count), 32'd3);

        // Continuous run past 16 wraps: count wraps modulo 2^WBITS.
        resetDut();
        applyStimulus(0, 1'b0, c);
        waitUntil(c + 550);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #3;
        checkOutput("t3_wrap_modulo", 32'(wrap_count), 32'd1);

        // One-wrap run paused for 10 cycles: done shifts from c+33 to c+43.
        resetDut();
        applyStimulus(1, 1'b0, c);
        exp_q.push_back('{due_cyc: c + 43, wc: 1});
        waitUntil(c + 10);
        pause = 1'b1;
        waitUntil(c + 20);
        pause = 1'b0;
        #3;
        checkOutput("t4_no_enable_in_pause", en_count, 32'd2);
        checkOutput("t4_busy_in_pause", 32'(busy), 32'd1);
        waitUntil(c + 50);
        #3;
        checkOutput("t4_enable_count", en_count, 32'd8);
        checkOutput("t4_wrap_count", 32'(wrap_count), 32'd1);
        checkOutput("t4_busy_after", 32'(busy), 32'd0);

        // Stop and pause together on the final wrap's enable cycle.
        resetDut();
        applyStimulus(1, 1'b0, c);
        waitUntil(c + 32);
        stop  = 1'b1;
        pause = 1'b1;
        #1;
        checkOutput("t5_enable_suppressed", 32'(counter_enable), 32'd0);
        @(negedge clk);
        stop  = 1'b0;
        pause = 1'b0;
        #3;
        checkOutput("t5_idle_after", 32'(busy), 32'd0);
        checkOutput("t5_wrap_count", 32'(wrap_count), 32'd0);
        checkOutput("t5_enable_count", en_count, 32'd7);
        waitUntil(c + 40);

        // Request 12 clamps to 8 wraps; start held through RUN and DONE.
        resetDut();
        applyStimulus(12, 1'b1, c);
        exp_q.push_back('{due_cyc: c + 257, wc: 8});
        waitUntil(c + 258);
        #1;
        checkOutput("t6_start_ignored_in_done", 32'(busy), 32'd0);
        start = 1'b0;
        #2;
        checkOutput("t6_wrap_count", 32'(wrap_count), 32'd8);
        checkOutput("t6_enable_count", en_count, 32'd64);

        // Reset asserted on an enable cycle after one wrap.
        resetDut();
        applyStimulus(2, 1'b0, c);
        waitUntil(c + 36);
        reset = 1'b0;
        #1;
        checkOutput("t7_enable_async", 32'(counter_enable), 32'd0);
        checkOutput("t7_busy_async", 32'(busy), 32'd0);
        checkOutput("t7_done_async", 32'(done), 32'd0);
        checkOutput("t7_wrap_count_async", 32'(wrap_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        waitUntil(c + 50);
        #3;
        checkOutput("t7_idle_after_release", 32'(busy), 32'd0);
        checkOutput("t7_enable_count", en_count, 32'd8);
        checkOutput("t7_wrap_count_after", 32'(wrap_count), 32'd0);

        checkOutput("pending_done_events", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
